dm_bus_arbiter: RTL
===================

Name: dm_bus_arbiter

Overview:
- Shares the single data-memory port (DM plus byte-enable path) between the M-stage load/store and an external requester (debug loader / DMA-style engine).
- Sits between the EtoM stage outputs and DM.
- CPU has default priority; a starvation counter and a bounded lock give the external port guaranteed progress.
- cpu_stall feeds the stall controller to freeze F..M when the CPU loses the bus.

Parameters:
- STARVE_LIMIT, 4: cycles ext_req may wait ungranted before a forced ext grant (legal 1..15).
- LOCK_MAX, 8: max consecutive ext-owned cycles while ext_lock is held (legal 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  M-stage memory access this cycle (load or store)
- cpu_we  in  1  M-stage store
- cpu_addr  in  32  byte address (AO)
- cpu_wdata  in  32  store data (forwarded rt)
- cpu_be  in  4  byte enables from BE
- cpu_rdata  out  32  load data to drext
- cpu_stall  out  1  CPU request not served this cycle
- ext_req  in  1  external access request
- ext_we  in  1  external write
- ext_lock  in  1  request to keep the bus on following cycles
- ext_addr  in  32  byte address
- ext_wdata  in  32  write data
- ext_be  in  4  byte enables
- ext_gnt  out  1  external access served this cycle
- ext_rdata  out  32  external read data
- mem_we  out  1  DM write enable
- mem_addr  out  32  DM address
- mem_wdata  out  32  DM write data
- mem_be  out  4  DM byte enables
- mem_rdata  in  32  DM combinational read data

Behaviour:
- One owner per cycle. Grant logic is combinational; state and counters are registered.
- Access completes in the granted cycle: write commits at that rising edge, read data is valid that cycle (zero-wait DM).
- States:
  - S_CPU: owner = EXT if ext_req && (!cpu_req || starve_cnt==STARVE_LIMIT); otherwise owner = CPU when cpu_req; otherwise none.
  - S_LOCK: owner = EXT if ext_req; otherwise CPU rules as in S_CPU.
- Transitions:
  - S_CPU -> S_LOCK when ext_gnt && ext_lock && LOCK_MAX>1.
  - S_LOCK -> S_CPU when !ext_req, or !ext_lock, or lock_cnt reaches LOCK_MAX.
  - After a forced lock exit, the next cycle is CPU-priority: the starvation override is ignored for one cycle.
- lock_cnt (4 bits): loaded to 1 on the entering grant, +1 per ext_gnt in S_LOCK, cleared on exit.
- starve_cnt (4 bits): +1 each cycle with ext_req && !ext_gnt, saturates at STARVE_LIMIT, cleared on ext_gnt or when ext_req is low.
- Mux:
  - mem_* carry the owner's fields.
  - With no owner: mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - mem_we = owner_we && owner_req.
- cpu_stall = cpu_req && owner != CPU. ext_gnt = owner == EXT.
- cpu_rdata and ext_rdata both equal mem_rdata. They are meaningful only when served.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: CPU wins, ext waits, counter increments.
- Reset (any cycle, including mid-lock):
  - state S_CPU, starve_cnt 0, lock_cnt 0.
  - While reset is high: ext_gnt=0, cpu_stall=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- The CPU request is level-held across stalls. The arbiter never drops a stalled CPU request; the M stage re-presents it.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_cpu_stall [31:0]: cycles with cpu_stall=1.
  - stat_ext_gnt [31:0]: cycles with ext_gnt=1.
  - stat_forced [15:0]: starvation-forced grants.
- All three clear on reset and wrap on overflow.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then CPU-only traffic: cpu store addr 0x10, be 4'b1111, data 0x12345678, then load 0x10 -> mem_we=1 in cycle 1, cpu_rdata=0x12345678 in cycle 2, cpu_stall=0 throughout.
- Ext read 0x20 with cpu_req=0 -> ext_gnt=1 the same cycle, ext_rdata=DM[0x20], starve_cnt stays 0.
- cpu_req and ext_req held high continuously, STARVE_LIMIT=4 -> ext_gnt low for 4 cycles, high on the 5th with cpu_stall=1 that cycle, then the pattern repeats.
- ext_lock=1 with ext_req held for 12 cycles and cpu_req held, LOCK_MAX=8 -> 8 consecutive ext_gnt, then one CPU-owned cycle (cpu_stall=0), then ext regains the bus only via starvation.
- Reset asserted on the 3rd cycle of a lock -> that cycle and the next show no grants and mem_we=0; after release, CPU wins the first simultaneous request.
- With DM_ARB_STATS_EN, run the starvation scenario for 20 cycles -> stat_forced=4, stat_ext_gnt=4, stat_cpu_stall=4.

Source files
------------

// File: rtl/dm_bus_arbiter.sv
// Data-memory port arbiter: CPU M-stage priority, external port guaranteed by starvation/lock limits.
// Optional DM_ARB_STATS_EN adds stall/grant/forced-grant counters.
module dm_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_be,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0] stat_cpu_stall,
  output logic [31:0] stat_ext_gnt,
  output logic [15:0] stat_forced
`endif
);

  typedef enum logic {S_CPU, S_LOCK} state_t;

  localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);
  localparam logic [3:0] LOCK_L   = 4'(LOCK_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] lock_cnt;
  logic       cpu_prio;
  logic       ext_own;
  logic       cpu_own;
  logic       forced;

  // cpu_prio suppresses the starvation override for the cycle after a capped lock.
  always_comb begin
    ext_own = 1'b0;
    cpu_own = 1'b0;
    forced  = 1'b0;
    if (!reset) begin
      if (state == S_LOCK && ext_req) begin
        ext_own = 1'b1;
      end else if (ext_req && !cpu_req) begin
        ext_own = 1'b1;
      end else if (ext_req && cpu_req && starve_cnt == STARVE_L && !cpu_prio) begin
        ext_own = 1'b1;
        forced  = 1'b1;
      end
      cpu_own = cpu_req && !ext_own;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (ext_own) begin
      mem_we    = ext_we && ext_req;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_be    = ext_be;
    end else if (cpu_own) begin
      mem_we    = cpu_we && cpu_req;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end
  end

  assign ext_gnt   = ext_own;
  assign cpu_stall = cpu_req && !cpu_own && !reset;
  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      starve_cnt <= 4'd0;
      lock_cnt   <= 4'd0;
      cpu_prio   <= 1'b0;
    end else begin
      cpu_prio <= 1'b0;
      if (ext_own || !ext_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt < STARVE_L) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      case (state)
        S_CPU: begin
          if (ext_own && ext_lock && LOCK_MAX > 1) begin
            state    <= S_LOCK;
            lock_cnt <= 4'd1;
          end
        end
        S_LOCK: begin
          if (!ext_req || !ext_lock) begin
            state    <= S_CPU;
            lock_cnt <= 4'd0;
          end else if (lock_cnt + 4'd1 == LOCK_L) begin
            state    <= S_CPU;
            lock_cnt <= 4'd0;
            cpu_prio <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 4'd1;
          end
        end
        default: begin
          state    <= S_CPU;
          lock_cnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_stall <= 32'd0;
      stat_ext_gnt   <= 32'd0;
      stat_forced    <= 16'd0;
    end else begin
      stat_cpu_stall <= stat_cpu_stall + {31'd0, cpu_stall};
      stat_ext_gnt   <= stat_ext_gnt + {31'd0, ext_gnt};
      stat_forced    <= stat_forced + {15'd0, forced};
    end
  end
`endif

endmodule
